// File: rtl/softmax_writeback_pkg.sv
// Shared configuration for the softmax writeback block: default vector geometry
// macros and the writeback FSM state encoding.
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef FIXPOINT_INT
`define FIXPOINT_INT 22
`endif
`ifndef FIXPOINT_FRAC
`define FIXPOINT_FRAC 10
`endif

package softmax_writeback_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } wb_state_e;

endpackage

// File: rtl/softmax_writeback_if.sv
// Vector capture and element write-stream bundle between the softmax producer,
// the writeback block and the downstream memory writer.
interface softmax_writeback_if #(
    parameter int ELEMS  = `ARRAYWIDTH,
    parameter int DW     = `FIXPOINT_INT + `FIXPOINT_FRAC,
    parameter int OUT_W  = 16,
    parameter int ADDR_W = 10
);
    logic                  vec_valid;
    logic [ELEMS*DW-1:0]   vec_data;
    logic                  vec_ready;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [OUT_W-1:0]      wr_data;

    modport master (
        output vec_valid, vec_data, wr_ready,
        input  vec_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  vec_valid, vec_data, wr_ready,
        output vec_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/softmax_wb_quant.sv
// Fixed-point narrowing of one softmax element: clamp negatives to zero, drop
// fraction bits, saturate. Define SOFTMAX_WB_ROUND_EN to round half-up instead of truncating.
module softmax_wb_quant #(
    parameter int DW       = 32,
    parameter int IN_FRAC  = 10,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 8
) (
    input  logic [DW-1:0]    i_elem,
    output logic [OUT_W-1:0] o_word
);
    localparam int SH     = IN_FRAC - OUT_FRAC;
    localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
    localparam logic [DW:0] MAX_OUT = (DW+1)'({OUT_W{1'b1}});
`ifdef SOFTMAX_WB_ROUND_EN
    localparam logic [DW:0] RND = (SH > 0) ? ((DW+1)'(1) << RND_SH) : '0;
`else
    localparam logic [DW:0] RND = '0;
`endif

    logic [DW:0] w_sum;
    logic [DW:0] w_shift;

    // One extra bit keeps the rounding add from wrapping near the positive maximum
    assign w_sum   = {1'b0, i_elem} + RND;
    assign w_shift = w_sum >> SH;

    // Clamp negative inputs, saturate oversized results
    always_comb begin
        if (i_elem[DW-1]) begin
            o_word = '0;
        end else if (w_shift > MAX_OUT) begin
            o_word = '1;
        end else begin
            o_word = w_shift[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/softmax_writeback.sv
// Captures softmax result vectors into a 2-deep buffer and streams them out as
// narrowed words with incrementing write addresses. Rounding via SOFTMAX_WB_ROUND_EN.
module softmax_writeback
    import softmax_writeback_pkg::*;
#(
    parameter int ELEMS     = `ARRAYWIDTH,
    parameter int DW        = `FIXPOINT_INT + `FIXPOINT_FRAC,
    parameter int IN_FRAC   = `FIXPOINT_FRAC,
    parameter int OUT_W     = 16,
    parameter int OUT_FRAC  = 8,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    softmax_writeback_if.slave bus,
    output logic               row_done,
    output logic               busy,
    output logic               overflow
);
    localparam int                IDX_W    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ELEMS - 1);

    logic [ELEMS*DW-1:0] r_fifo [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;
    wb_state_e           r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_wr_valid;
    logic [OUT_W-1:0]    r_wr_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_row_done;
    logic                r_overflow;

    logic                w_ready;
    logic                w_push;
    logic                w_accept;
    logic                w_last;
    logic                w_pop;
    logic [1:0]          w_count_next;
    logic [ELEMS*DW-1:0] w_next_vec;
    logic [IDX_W-1:0]    w_next_idx;
    logic [OUT_W-1:0]    w_q [ELEMS];

    assign w_ready      = (r_count < 2'd2);
    assign w_push       = bus.vec_valid && w_ready;
    assign w_accept     = r_wr_valid && bus.wr_ready;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_pop        = w_accept && w_last;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Pick the vector/element presented next; a row finishing while a single
    // entry is buffered takes the incoming vector directly to avoid a bubble.
    always_comb begin
        w_next_vec = r_fifo[r_rptr];
        w_next_idx = '0;
        if (w_accept) begin
            if (w_last) begin
                if (r_count == 2'd2) begin
                    w_next_vec = r_fifo[~r_rptr];
                end else begin
                    w_next_vec = bus.vec_data;
                end
                w_next_idx = '0;
            end else begin
                w_next_idx = r_idx + IDX_W'(1);
            end
        end else begin
            w_next_idx = '0;
        end
    end

    for (genvar g = 0; g < ELEMS; g++) begin : g_quant
        softmax_wb_quant #(
            .DW       (DW),
            .IN_FRAC  (IN_FRAC),
            .OUT_W    (OUT_W),
            .OUT_FRAC (OUT_FRAC)
        ) u_quant (
            .i_elem (w_next_vec[g*DW +: DW]),
            .o_word (w_q[g])
        );
    end

    // Two-slot vector buffer with ping-pong pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else if (clear) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= bus.vec_data;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_next;
        end
    end

    // Writeback FSM with registered stream, row_done and overflow outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_wr_addr  <= BASE;
            r_row_done <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= '0;
            r_wr_addr  <= BASE;
            r_row_done <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_row_done <= w_pop;
            if (bus.vec_valid && !w_ready) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_count != 2'd0) begin
                        r_state    <= SEND;
                        r_wr_valid <= 1'b1;
                        r_wr_data  <= w_q[w_next_idx];
                        r_idx      <= w_next_idx;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        if (w_last && (w_count_next == 2'd0)) begin
                            r_state    <= IDLE;
                            r_wr_valid <= 1'b0;
                            r_idx      <= '0;
                        end else begin
                            r_wr_data <= w_q[w_next_idx];
                            r_idx     <= w_next_idx;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_ready = w_ready;
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_addr   = r_wr_addr;
    assign row_done      = r_row_done;
    assign overflow      = r_overflow;
    assign busy          = (r_state == SEND) || (r_count != 2'd0);
endmodule

// File: tb/tb_softmax_writeback.sv
// Randomized self-checking bench for softmax_writeback against a queue-based
// reference model of the captured rows and expected output words.
module tb_softmax_writeback;
    localparam int ELEMS = 4, DW = 32, IN_FRAC = 10, OUT_W = 16, OUT_FRAC = 8, ADDR_W = 10;
    localparam logic [9:0] BASE = 10'h3FE;
    localparam longint SCALE = 64'd1 << (IN_FRAC - OUT_FRAC);
`ifdef SOFTMAX_WB_ROUND_EN
    localparam logic [15:0] R1FF = 16'h0080;
`else
    localparam logic [15:0] R1FF = 16'h007F;
`endif
    localparam logic [15:0] EXP_W [8] = '{16'h0100, 16'h0080, 16'h0040, 16'h0000,
                                          R1FF, 16'h0000, 16'hFFFF, 16'hFFFF};
    localparam logic [9:0]  EXP_A [8] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001,
                                          10'h002, 10'h003, 10'h004, 10'h005};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic row_done, busy, overflow;
    int   n_checks = 0;
    int   n_errors = 0;

    softmax_writeback_if #(.ELEMS(ELEMS), .DW(DW), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus();

    softmax_writeback #(
        .ELEMS(ELEMS), .DW(DW), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC),
        .ADDR_W(ADDR_W), .BASE_ADDR(32'h3FE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .row_done(row_done), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_q(input logic [31:0] e);
        longint v;
        v = longint'($signed(e));
        if (v < 0) return 16'h0000;
`ifdef SOFTMAX_WB_ROUND_EN
        v = v + SCALE / 2;
`endif
        v = v / SCALE;
        if (v > 65535) return 16'hFFFF;
        return v[15:0];
    endfunction

    function automatic logic [31:0] rand_elem();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 32'h3FFFF));
            1: return -32'($urandom_range(1, 5000));
            2: return $urandom;
            default: return 32'h3FFFC + 32'($urandom_range(0, 7));
        endcase
    endfunction

    // Reference model state
    logic [15:0] mq[$];
    logic [25:0] got_q[$];
    int          m_rows = 0;
    int          m_elem = 0;
    int          n_words = 0;
    logic [9:0]  m_addr = BASE;
    logic        m_ovf = 1'b0, m_rd_exp = 1'b0, m_fresh = 1'b0, p_stall = 1'b0;
    logic [15:0] p_data = 16'h0;
    logic [9:0]  p_addr = 10'h0;

    // Monitor: check state between edges, then apply the upcoming edge to the model
    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_rows = 0; m_elem = 0; m_addr = BASE; m_ovf = 1'b0;
            m_rd_exp = 1'b0; m_fresh = 1'b0; p_stall = 1'b0;
        end else begin
            check_val("wr_valid", bus.wr_valid, (m_rows > 0) && !m_fresh);
            check_val("busy", busy, m_rows > 0);
            check_val("vec_ready", bus.vec_ready, m_rows < 2);
            check_val("overflow", overflow, m_ovf);
            check_val("row_done", row_done, m_rd_exp);
            if (p_stall) begin
                check_val("hold_data", bus.wr_data, p_data);
                check_val("hold_addr", bus.wr_addr, p_addr);
            end
            p_stall = bus.wr_valid && !bus.wr_ready && !clear;
            p_data = bus.wr_data;
            p_addr = bus.wr_addr;
            m_rd_exp = 1'b0;
            m_fresh = 1'b0;
            if (clear) begin
                mq.delete();
                m_rows = 0; m_elem = 0; m_addr = BASE; m_ovf = 1'b0;
            end else begin
                automatic bit cap = bus.vec_valid && (m_rows < 2);
                automatic bit pop = 1'b0;
                if (bus.vec_valid && m_rows >= 2) m_ovf = 1'b1;
                if (bus.wr_valid && bus.wr_ready) begin
                    if (mq.size() == 0) begin
                        check_val("spurious_word", 1, 0);
                    end else begin
                        check_val("wr_data", bus.wr_data, mq.pop_front());
                    end
                    check_val("wr_addr", bus.wr_addr, m_addr);
                    got_q.push_back({bus.wr_addr, bus.wr_data});
                    m_addr = m_addr + 10'd1;
                    n_words++;
                    if (m_elem == ELEMS - 1) begin
                        m_elem = 0; pop = 1'b1; m_rd_exp = 1'b1;
                    end else begin
                        m_elem++;
                    end
                end
                if (cap) begin
                    for (int i = 0; i < ELEMS; i++) mq.push_back(ref_q(bus.vec_data[i*DW +: DW]));
                    if (m_rows == 0) m_fresh = 1'b1;
                end
                m_rows = m_rows + int'(cap) - int'(pop);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [ELEMS*DW-1:0] v);
        bus.vec_valid = 1'b1;
        bus.vec_data  = v;
        cyc();
        bus.vec_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300; k++) begin
            if (!busy && mq.size() == 0) break;
            cyc();
        end
        check_val("idle_busy", busy, 0);
        check_val("idle_pending", mq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wr_valid"}, bus.wr_valid, 0);
        check_val({tag, "_wr_data"}, bus.wr_data, 0);
        check_val({tag, "_wr_addr"}, bus.wr_addr, BASE);
        check_val({tag, "_row_done"}, row_done, 0);
        check_val({tag, "_overflow"}, overflow, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_vec_ready"}, bus.vec_ready, 1);
    endtask

    initial begin
        int w0;
        bus.vec_valid = 1'b0;
        bus.vec_data  = '0;
        bus.wr_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cyc();

        // Directed rows: basic scaling, rounding edge, clamp and saturation, address wrap
        got_q.delete();
        send_vec({32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0000_0400});
        wait_idle();
        send_vec({32'h7FFF_FFFF, 32'h0010_0000, 32'hFFFF_FC00, 32'h0000_01FF});
        wait_idle();
        check_val("dir_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            check_val($sformatf("dir_w%0d", i), got_q[i][15:0], EXP_W[i]);
            check_val($sformatf("dir_a%0d", i), got_q[i][25:16], EXP_A[i]);
        end

        // Third strobe into a full buffer is dropped
        bus.wr_ready = 1'b0;
        w0 = n_words;
        for (int i = 0; i < 3; i++) send_vec({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
        repeat (3) cyc();
        check_val("ovf_set", overflow, 1);
        bus.wr_ready = 1'b1;
        wait_idle();
        check_val("ovf_words", n_words - w0, 8);
        check_val("ovf_sticky", overflow, 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_val("clr_ovf", overflow, 0);

        // Stall pattern 1,0,0,1
        w0 = n_words;
        send_vec({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
        for (int k = 0; k < 12; k++) begin
            bus.wr_ready = ((k % 4) == 0) || ((k % 4) == 3);
            cyc();
        end
        bus.wr_ready = 1'b1;
        wait_idle();
        check_val("stall_words", n_words - w0, 4);

        // Clear mid-row, then the next row restarts at BASE
        send_vec({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
        cyc();
        cyc();
        bus.wr_ready = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        bus.wr_ready = 1'b1;
        check_val("clr_wr_valid", bus.wr_valid, 0);
        check_val("clr_wr_addr", bus.wr_addr, BASE);
        got_q.delete();
        send_vec({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
        wait_idle();
        check_val("clr_next_cnt", got_q.size(), 4);
        if (got_q.size() > 0) check_val("clr_next_addr", got_q[0][25:16], BASE);

        // Randomized traffic with occasional clear
        for (int k = 0; k < 600; k++) begin
            bus.vec_valid = ($urandom_range(0, 2) == 0);
            bus.vec_data  = {rand_elem(), rand_elem(), rand_elem(), rand_elem()};
            bus.wr_ready  = ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 79) == 0);
            cyc();
        end
        bus.vec_valid = 1'b0;
        clear = 1'b0;
        bus.wr_ready = 1'b1;
        wait_idle();

        // Reset mid-row: row is abandoned and never resumes
        send_vec({rand_elem(), rand_elem(), rand_elem(), rand_elem()});
        cyc();
        cyc();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cyc();
        check_val("post_rst_wr_valid", bus.wr_valid, 0);
        check_val("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/softmax_writeback.md
SOFTMAX_WRITEBACK -- requirements
Module: softmax_writeback

Interface
REQ-001 SHALL have parameter ELEMS, default `ARRAYWIDTH, vector element count.
REQ-002 SHALL have parameter DW, default `FIXPOINT_INT+`FIXPOINT_FRAC, input element width.
REQ-003 SHALL have parameter IN_FRAC, default `FIXPOINT_FRAC, input fraction bits.
REQ-004 SHALL have parameters OUT_W and OUT_FRAC, defaults 16 and 8, the output word width and its fraction bits, with IN_FRAC >= OUT_FRAC.
REQ-005 SHALL have parameters ADDR_W and BASE_ADDR, defaults 10 and 0, the write address width and start address.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-008 SHALL have port vec_valid, input, 1, one-cycle strobe marking a valid softmax result vector.
REQ-009 SHALL have port vec_data, input, ELEMS*DW, the softmax result vector; element i occupies bits [(i+1)*DW-1:i*DW].
REQ-010 SHALL have port vec_ready, output, 1, high when the capture buffer has a free slot.
REQ-011 SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, ADDR_W) and wr_data (output, OUT_W), forming the element write stream.
REQ-012 SHALL have port clear, input, 1, synchronous flush and address restart.
REQ-013 SHALL have ports row_done (output, 1, pulse), busy (output, 1) and overflow (output, 1, sticky).

Function
REQ-014 SHALL contain a 2-entry vector FIFO; vec_ready = (count < 2), taken from the registered count with no same-cycle bypass.
REQ-015 SHALL capture vec_data on a clk edge with vec_valid=1 and vec_ready=1; when vec_valid=1 and vec_ready=0, the vector SHALL be dropped and overflow set.
REQ-016 SHALL use FSM states IDLE, SEND: IDLE->SEND when FIFO non-empty; SEND->IDLE after the last element is accepted with FIFO empty; otherwise SHALL stay in SEND and continue with the next row.
REQ-017 SHALL serialize elements in order 0..ELEMS-1, one word per wr_valid&&wr_ready handshake.
REQ-018 SHALL have latency as follows: for a vector captured at edge E0 into an empty, idle block, wr_valid SHALL be high after edge E1.
REQ-019 SHALL keep wr_valid, wr_data and wr_addr stable while wr_valid=1 and wr_ready=0.
REQ-020 SHALL present back-to-back rows with no bubble: element 0 of the next row is presented in the cycle after the last element of the previous row is accepted.
REQ-021 SHALL pop the FIFO on acceptance of element ELEMS-1; a pop and a capture on the same edge SHALL leave the count unchanged.
REQ-022 SHALL start wr_addr at BASE_ADDR, increment it by 1 per accepted word, and wrap modulo 2^ADDR_W.
REQ-023 SHALL pulse row_done for exactly one cycle, in the cycle after the handshake of element ELEMS-1.
REQ-024 SHALL compute busy = (state==SEND) or FIFO non-empty.
REQ-025 SHALL convert each element treated as signed DW: negative -> 0; right-shift by IN_FRAC-OUT_FRAC; results above 2^OUT_W-1 saturate to all-ones.
REQ-026 SHALL, when clear=1, empty the FIFO, enter IDLE, set wr_addr=BASE_ADDR and overflow=0, and drive wr_valid=0 from the next cycle; clear has priority over a simultaneous capture.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: FIFO empty, state IDLE, wr_addr=BASE_ADDR, wr_valid=0, wr_data=0, row_done=0, overflow=0, busy=0, vec_ready=1 (vec_ready follows the empty FIFO).
REQ-028 SHALL, on reset asserted mid-row, abandon that row; the row SHALL NOT be resumed after release.

Configuration
REQ-029 SHALL, when macro SOFTMAX_WB_ROUND_EN is defined, round half-up by adding 2^(IN_FRAC-OUT_FRAC-1) before the shift (saturation still applies); when undefined, truncate.

Structure
REQ-030 SHALL place ARRAYWIDTH, FIXPOINT_INT, FIXPOINT_FRAC and the FSM state encoding in the shared config include.
REQ-031 SHALL implement the conversion as the combinational sub-module softmax_wb_quant, one instance per output word.

Verification (IN_FRAC=10, OUT_FRAC=8, OUT_W=16, ELEMS=4)
REQ-032 SHALL cover: vector {0x400,0x200,0x100,0x0} with wr_ready=1 -> words 0x100,0x80,0x40,0x0 at addresses 0..3, then row_done after the 4th word.
REQ-033 SHALL cover: element 0x1FF -> 0x7F without the macro, 0x80 with SOFTMAX_WB_ROUND_EN defined.
REQ-034 SHALL cover: elements 0xFFFFFC00 and 0x00100000 -> 0x0000 and 0xFFFF.
REQ-035 SHALL cover: three vec_valid strobes on consecutive cycles with wr_ready=0 -> the third is dropped, overflow=1, and exactly 8 words follow once wr_ready=1.
REQ-036 SHALL cover: wr_ready toggling 1,0,0,1 -> wr_data and wr_addr held during the stall, and no word duplicated or skipped.
REQ-037 SHALL cover: BASE_ADDR=0x3FE with 4 words -> addresses 0x3FE,0x3FF,0x000,0x001; then clear mid-row -> wr_valid=0 next cycle and the next row starts at 0x3FE.
